// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, FSM states and instruction-class decode for control_unit
package ctrl_pkg;

  localparam int IMM_W_DEFAULT = 15;

  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_BEQ   = 5'b10010;
  localparam logic [4:0] OP_BNE   = 5'b10011;
  localparam logic [4:0] OP_JMP   = 5'b10100;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic beq;
    logic bne;
    logic jmp;
    logic halt;
    logic nop;
  } instr_class_t;

  // Exactly one bit set; anything unrecognised falls into nop.
  function automatic instr_class_t decode_class(input logic [4:0] op);
    instr_class_t c;
    c = '0;
    if (op[4:3] == 2'b00) begin
      c.alu_r = 1'b1;
    end else if (op[4:3] == 2'b01) begin
      c.alu_i = 1'b1;
    end else begin
      case (op)
        OP_LOAD:  c.load  = 1'b1;
        OP_STORE: c.store = 1'b1;
        OP_BEQ:   c.beq   = 1'b1;
        OP_BNE:   c.bne   = 1'b1;
        OP_JMP:   c.jmp   = 1'b1;
        OP_HALT:  c.halt  = 1'b1;
        default:  c.nop   = 1'b1;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// rtl/control_unit_instr_decoder.sv - combinational IR split into fields, sign-extended immediate and class one-hot
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEFAULT
) (
  input  logic [31:0]  ir,
  output logic [4:0]   opcode,
  output logic [3:0]   rd,
  output logic [3:0]   rs,
  output logic [3:0]   rt,
  output logic [31:0]  imm_ext,
  output instr_class_t cls
);

  assign opcode  = ir[31:27];
  assign rd      = ir[26:23];
  assign rs      = ir[22:19];
  assign rt      = ir[18:15];
  assign imm_ext = {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign cls     = decode_class(ir[31:27]);

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute FSM; CTRL_PERF_COUNT_EN adds instr_count
module control_unit
  import ctrl_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic [1:0]  flag,
  output logic [4:0]  opcode,
  output logic [3:0]  Rd,
  output logic [3:0]  Rs,
  output logic [3:0]  Rt,
  output logic [31:0] imm_ext,
  output logic        en_exe_pulse,
  output logic        en_pc_pulse,
  output logic        branch_taken,
  output logic        in2_muxcontrol,
  output logic        wv_muxcontrol,
  output logic        regwrite,
`ifdef CTRL_PERF_COUNT_EN
  output logic [31:0] instr_count,
`endif
  output logic        halted
);

  state_t       state, next_state;
  logic [31:0]  ir;
  instr_class_t cls;
  logic         in2_sel;
  logic         flag_neg_unused;

  assign flag_neg_unused = flag[1];

  instr_decoder #(.IMM_W(IMM_W)) u_decoder (
    .ir      (ir),
    .opcode  (opcode),
    .rd      (Rd),
    .rs      (Rs),
    .rt      (Rt),
    .imm_ext (imm_ext),
    .cls     (cls)
  );

  assign in2_sel = cls.alu_r | cls.beq | cls.bne;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && instr_valid) begin
        ir <= instr_data;
      end
    end
  end

  // Outputs are gated by reset so a pending memory request drops in the reset cycle itself.
  always_comb begin
    next_state     = state;
    instr_req      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    en_exe_pulse   = 1'b0;
    en_pc_pulse    = 1'b0;
    branch_taken   = 1'b0;
    in2_muxcontrol = 1'b0;
    wv_muxcontrol  = 1'b0;
    regwrite       = 1'b0;
    halted         = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          instr_req = 1'b1;
          if (instr_valid) next_state = S_DECODE;
        end
        S_DECODE: begin
          in2_muxcontrol = in2_sel;
          if (cls.halt) begin
            next_state = S_HALT;
          end else if (cls.nop) begin
            en_pc_pulse = 1'b1;
            next_state  = S_FETCH;
          end else begin
            next_state = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          en_exe_pulse   = 1'b1;
          in2_muxcontrol = in2_sel;
          if (cls.alu_r || cls.alu_i)                 next_state = S_WB;
          else if (cls.load || cls.store)             next_state = S_MEM;
          else if (cls.beq || cls.bne || cls.jmp)     next_state = S_BRANCH;
          else                                        next_state = S_FETCH;
        end
        S_MEM: begin
          mem_read  = cls.load;
          mem_write = cls.store;
          if (mem_ready) begin
            if (cls.load) begin
              next_state = S_WB;
            end else begin
              en_pc_pulse = 1'b1;
              next_state  = S_FETCH;
            end
          end
        end
        S_WB: begin
          regwrite      = 1'b1;
          en_pc_pulse   = 1'b1;
          wv_muxcontrol = cls.load;
          next_state    = S_FETCH;
        end
        S_BRANCH: begin
          branch_taken = (cls.beq & flag[0]) | (cls.bne & ~flag[0]) | cls.jmp;
          en_pc_pulse  = 1'b1;
          next_state   = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
    end else if (en_pc_pulse) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule
